// File: rtl/l1a_fifo_pkg.sv
// L1A FIFO record format and shared types.
// Used by the writer and by the DMB L1A checker.
package l1a_fifo_pkg;

  localparam int ENT_FLAG_W = 7;

  localparam logic [3:0] MK_B4_HI = 4'hB;
  localparam logic [3:0] MK_B4_LO = 4'h4;
  localparam logic [3:0] MK_L1L   = 4'hD;
  localparam logic [3:0] MK_L1H   = 4'hE;
  localparam logic [3:0] MK_B5    = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_WR1,
    ST_WR2,
    ST_WR3
  } wr_state_e;

  typedef struct packed {
    logic [23:0]           l1a;
    logic [11:0]           bxn;
    logic [ENT_FLAG_W-1:0] flags;
  } pend_entry_t;

  function automatic logic [15:0] rec_word(
    input wr_state_e   st,
    input pend_entry_t e
  );
    logic [15:0] w;
    w = 16'h0000;
    case (st)
      ST_WR0:  w = {MK_B4_HI, MK_B4_LO, 1'b0, e.flags};
      ST_WR1:  w = {MK_L1L, e.l1a[11:0]};
      ST_WR2:  w = {MK_L1H, e.l1a[23:12]};
      ST_WR3:  w = {MK_B5, e.bxn};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/l1a_pend_queue.sv
// Pending-event queue between L1A capture and record serialiser.
// A push into a full queue is accepted when a pop happens in the same cycle.
module l1a_pend_queue
  import l1a_fifo_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        push,
  input  logic        pop,
  input  pend_entry_t din,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output pend_entry_t head
);

  pend_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Slot under rd_ptr is read before this edge, so a full push+pop is safe.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/l1a_fifo_writer.sv
// L1A FIFO writer: numbers each L1A, queues it, and
// serialises every queued event as a 4-word record.
module l1a_fifo_writer
  import l1a_fifo_pkg::*;
#(
  parameter int  DATA_W     = 16,
  parameter int  FLAG_W     = 7,
  parameter int  PEND_DEPTH = 4,
  localparam int CW         = $clog2(PEND_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              L1A,
  input  logic              L1A_CNT_RST,
  input  logic [11:0]       BXN,
  input  logic [FLAG_W-1:0] ACT_FLAGS,
  input  logic              FIFO_FULL,
  output logic              FIFO_WE,
  output logic [DATA_W-1:0] FIFO_DIN,
  output logic [23:0]       L1A_NUM,
  output logic [CW-1:0]     PEND_CNT,
  output logic              BUSY,
  output logic              OVERFLOW,
  input  logic              CLR_OVF
);

  wr_state_e   state;
  wr_state_e   state_nx;
  pend_entry_t rec;
  pend_entry_t head;
  pend_entry_t entry;
  logic        q_full;
  logic        q_empty;
  logic        load;
  logic        drop;
  logic [23:0] l1a_num_q;
  logic [23:0] cnt_nx;

  assign cnt_nx = L1A_CNT_RST ? 24'd1 : l1a_num_q + 24'd1;
  assign entry  = '{
    l1a:   cnt_nx,
    bxn:   BXN,
    flags: ENT_FLAG_W'(ACT_FLAGS)
  };
  assign drop   = L1A & q_full & ~load;

  l1a_pend_queue #(
    .DEPTH (PEND_DEPTH)
  ) u_queue (
    .CLK   (CLK),
    .RST   (RST),
    .push  (L1A),
    .pop   (load),
    .din   (entry),
    .full  (q_full),
    .empty (q_empty),
    .count (PEND_CNT),
    .head  (head)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          state_nx = ST_WR0;
          load     = 1'b1;
        end
      end
      ST_WR0: if (!FIFO_FULL) state_nx = ST_WR1;
      ST_WR1: if (!FIFO_FULL) state_nx = ST_WR2;
      ST_WR2: if (!FIFO_FULL) state_nx = ST_WR3;
      ST_WR3: begin
        if (!FIFO_FULL) begin
          if (!q_empty) begin
            state_nx = ST_WR0;
            load     = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    FIFO_WE  = (state != ST_IDLE) & ~FIFO_FULL;
    FIFO_DIN = rec_word(state, rec);
    BUSY     = (state != ST_IDLE) | ~q_empty;
  end

  // Record stays frozen for all four words, stalls included.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rec <= '0;
    end else if (load) begin
      rec <= head;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      l1a_num_q <= '0;
    end else if (L1A) begin
      l1a_num_q <= cnt_nx;
    end else if (L1A_CNT_RST) begin
      l1a_num_q <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OVERFLOW <= 1'b0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
    end else if (CLR_OVF) begin
      OVERFLOW <= 1'b0;
    end
  end

  assign L1A_NUM = l1a_num_q;

endmodule

// File: tb/tb_l1a_fifo_writer.sv
// Bench for l1a_fifo_writer: event-level reference model,
// scoreboard of expected FIFO words, directed and random phases.
module tb_l1a_fifo_writer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        L1A;
  logic        L1A_CNT_RST;
  logic [11:0] BXN;
  logic [6:0]  ACT_FLAGS;
  logic        FIFO_FULL;
  logic        CLR_OVF;
  logic        FIFO_WE;
  logic [15:0] FIFO_DIN;
  logic [23:0] L1A_NUM;
  logic [2:0]  PEND_CNT;
  logic        BUSY;
  logic        OVERFLOW;

  always #5 CLK = ~CLK;

  l1a_fifo_writer #(
    .DATA_W     (16),
    .FLAG_W     (7),
    .PEND_DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .L1A         (L1A),
    .L1A_CNT_RST (L1A_CNT_RST),
    .BXN         (BXN),
    .ACT_FLAGS   (ACT_FLAGS),
    .FIFO_FULL   (FIFO_FULL),
    .FIFO_WE     (FIFO_WE),
    .FIFO_DIN    (FIFO_DIN),
    .L1A_NUM     (L1A_NUM),
    .PEND_CNT    (PEND_CNT),
    .BUSY        (BUSY),
    .OVERFLOW    (OVERFLOW),
    .CLR_OVF     (CLR_OVF)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: event list, words left in the current record.
  typedef struct {
    int l1a;
    int bxn;
    int flags;
  } ev_t;

  ev_t         mq[$];
  logic [15:0] exp_q[$];
  int          m_cnt = 0;
  int          m_rem = 0;
  bit          m_ovf = 1'b0;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  logic [15:0] wlog[$];
  int          we_cyc[$];

  always @(posedge CLK) begin
    bit  popn;
    bit  drop;
    int  rem0;
    ev_t e;
    ev_t n;
    cyc++;
    if (RST) begin
      mq.delete();
      exp_q.delete();
      m_cnt = 0;
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      rem0 = m_rem;
      if (m_rem > 0 && !FIFO_FULL) m_rem--;
      popn = (rem0 == 0 || (rem0 == 1 && !FIFO_FULL)) && mq.size() > 0;
      if (popn) begin
        e = mq.pop_front();
        exp_q.push_back(16'(32'hB400 + e.flags));
        exp_q.push_back(16'(32'hD000 + (e.l1a % 4096)));
        exp_q.push_back(16'(32'hE000 + (e.l1a / 4096)));
        exp_q.push_back(16'(32'hC000 + e.bxn));
        m_rem = 4;
      end
      drop = 1'b0;
      if (L1A) begin
        m_cnt = L1A_CNT_RST ? 1 : (m_cnt + 1) % (1 << 24);
        if (mq.size() < DEPTH) begin
          n.l1a   = m_cnt;
          n.bxn   = int'(BXN);
          n.flags = int'(ACT_FLAGS);
          mq.push_back(n);
        end else begin
          drop = 1'b1;
        end
      end else if (L1A_CNT_RST) begin
        m_cnt = 0;
      end
      if (CLR_OVF) m_ovf = 1'b0;
      if (drop)    m_ovf = 1'b1;
    end
  end

  // Monitor / scoreboard.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("fifo_we", FIFO_WE, (m_rem != 0 && !FIFO_FULL));
      chk("pend_cnt", PEND_CNT, mq.size());
      chk("busy", BUSY, (m_rem != 0 || mq.size() != 0));
      chk("overflow", OVERFLOW, m_ovf);
      chk("l1a_num", L1A_NUM, m_cnt);
      if (m_rem == 0) begin
        chk("din_idle", FIFO_DIN, 16'h0000);
      end else if (exp_q.size() > 0) begin
        chk("din_word", FIFO_DIN, exp_q[0]);
      end
      if (FIFO_WE) begin
        wlog.push_back(FIFO_DIN);
        we_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h required=none", FIFO_DIN);
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_rem != 0 || mq.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_timeout", (n < 300), 1);
    tick();
  endtask

  task automatic pulse_l1a(input logic [11:0] bx, input logic [6:0] fl);
    L1A       = 1'b1;
    BXN       = bx;
    ACT_FLAGS = fl;
    tick();
    L1A       = 1'b0;
  endtask

  initial begin
    RST         = 1'b1;
    L1A         = 1'b0;
    L1A_CNT_RST = 1'b0;
    BXN         = '0;
    ACT_FLAGS   = '0;
    FIFO_FULL   = 1'b0;
    CLR_OVF     = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    RST = 1'b0;

    @(negedge CLK);
    chk("rst_we", FIFO_WE, 0);
    chk("rst_din", FIFO_DIN, 0);
    chk("rst_num", L1A_NUM, 0);
    chk("rst_pend", PEND_CNT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ovf", OVERFLOW, 0);
    tick();

    // Single event.
    wlog.delete();
    we_cyc.delete();
    pulse_l1a(12'h123, 7'h25);
    drain();
    chk("single_n", wlog.size(), 4);
    chk("single_w0", wlog[0], 16'hB425);
    chk("single_w1", wlog[1], 16'hD001);
    chk("single_w2", wlog[2], 16'hE000);
    chk("single_w3", wlog[3], 16'hC123);
    chk("single_gap", we_cyc[3] - we_cyc[0], 3);
    chk("single_busy", BUSY, 0);

    // Counter wrap.
    force dut.l1a_num_q = 24'hFFFFFE;
    m_cnt = 24'hFFFFFE;
    tick();
    release dut.l1a_num_q;
    wlog.delete();
    pulse_l1a(12'h0AB, 7'h01);
    repeat (3) tick();
    pulse_l1a(12'h0CD, 7'h02);
    drain();
    chk("wrap_n", wlog.size(), 8);
    chk("wrap_w1a", wlog[1], 16'hDFFF);
    chk("wrap_w2a", wlog[2], 16'hEFFF);
    chk("wrap_w1b", wlog[5], 16'hD000);
    chk("wrap_w2b", wlog[6], 16'hE000);

    // Burst: 7 consecutive L1As, the last one finds the queue full.
    wlog.delete();
    we_cyc.delete();
    for (int i = 0; i < 7; i++) pulse_l1a(12'($urandom), 7'($urandom));
    @(negedge CLK);
    chk("burst_ovf", OVERFLOW, 1);
    drain();
    chk("burst_n", wlog.size(), 24);
    chk("burst_span", we_cyc[23] - we_cyc[0], 23);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    @(negedge CLK);
    chk("clr_ovf", OVERFLOW, 0);
    tick();

    // Stall in WR1.
    wlog.delete();
    pulse_l1a(12'h456, 7'h11);
    tick();
    tick();
    FIFO_FULL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_we", FIFO_WE, 0);
      chk("stall_mk", FIFO_DIN[15:12], 4'hD);
    end
    @(posedge CLK);
    #1;
    FIFO_FULL = 1'b0;
    drain();
    chk("stall_n", wlog.size(), 4);
    chk("stall_w0", wlog[0], 16'hB411);
    chk("stall_w3", wlog[3], 16'hC456);

    // Counter reset together with L1A.
    for (int i = 0; i < 10; i++) begin
      pulse_l1a(12'($urandom), 7'($urandom));
      repeat (4) tick();
    end
    drain();
    wlog.delete();
    L1A_CNT_RST = 1'b1;
    pulse_l1a(12'h777, 7'h00);
    L1A_CNT_RST = 1'b0;
    @(negedge CLK);
    chk("cntrst_num", L1A_NUM, 1);
    drain();
    chk("cntrst_w1", wlog[1], 16'hD001);
    chk("cntrst_w2", wlog[2], 16'hE000);

    // Reset mid-record with two events pending.
    wlog.delete();
    L1A = 1'b1;
    repeat (3) tick();
    L1A = 1'b0;
    tick();
    @(negedge CLK);
    chk("prerst_pend", PEND_CNT, 2);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_we", FIFO_WE, 0);
    chk("midrst_pend", PEND_CNT, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_num", L1A_NUM, 0);
    chk("midrst_words", wlog.size(), 3);
    wlog.delete();
    tick();
    pulse_l1a(12'h001, 7'h7F);
    drain();
    chk("postrst_w1", wlog[1], 16'hD001);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      L1A         = ($urandom % 100) < 35;
      L1A_CNT_RST = ($urandom % 100) < 3;
      FIFO_FULL   = ($urandom % 100) < 25;
      CLR_OVF     = ($urandom % 100) < 5;
      RST         = ($urandom % 1000) < 2;
      BXN         = 12'($urandom);
      ACT_FLAGS   = 7'($urandom);
      tick();
    end
    L1A         = 1'b0;
    L1A_CNT_RST = 1'b0;
    FIFO_FULL   = 1'b0;
    CLR_OVF     = 1'b0;
    RST         = 1'b0;
    drain();
    chk("final_exp_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
